anton_neopixel_bus_arbiter: RTL and testbench

//  Bus-side controller for the neopixel raw core on busClk.
//  - Shares the core's single 14-bit register/buffer bus between two requesters (m0, m1), round-robin.
//  - Sequences frame commits: writes CTRL with run=1, then polls CTRL until run self-clears.
//  - Reports frameBusy/frameDone to software and animation logic.

---
 rtl/anton_neopixel_bus_arbiter_pkg.sv | 48 ++++
 rtl/anton_neopixel_bus_arbiter_rr.sv | 41 ++++
 rtl/anton_neopixel_bus_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_anton_neopixel_bus_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anton_neopixel_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : anton_neopixel_bus_arbiter_pkg
// Description : Register map, CTRL bit positions, FSM states and transfer
//               owner encoding for the neopixel bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package anton_neopixel_bus_arbiter_pkg;

    localparam logic [13:0] REG_MAX_LO = 14'h2000;
    localparam logic [13:0] REG_MAX_HI = 14'h2001;
    localparam logic [13:0] REG_CTRL   = 14'h2002;
    localparam logic [13:0] REG_STATE  = 14'h2003;

    localparam int CTRL_INIT  = 0;
    localparam int CTRL_LIMIT = 1;
    localparam int CTRL_RUN   = 2;
    localparam int CTRL_LOOP  = 3;
    localparam int CTRL_BIT32 = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_XFER    = 3'd1,
        ST_WR_ACK  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RD_ACK  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OWN_M0  = 2'd0,
        OWN_M1  = 2'd1,
        OWN_INT = 2'd2
    } owner_t;

    function automatic logic [7:0] ctrl_commit_word(input logic bit32,
                                                    input logic loop,
                                                    input logic limit);
        logic [7:0] w;
        w             = 8'h00;
        w[CTRL_BIT32] = bit32;
        w[CTRL_LOOP]  = loop;
        w[CTRL_RUN]   = 1'b1;
        w[CTRL_LIMIT] = limit;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/anton_neopixel_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : anton_rr_arbiter2
// Description : Two-way round-robin arbiter; on a tie the requester granted
//               last loses. Pointer moves only when i_advance is asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module anton_rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant,
    output logic       o_ptr
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        if (i_req == 2'b11) begin
            o_grant = ptr_q ? 2'b10 : 2'b01;
        end else begin
            o_grant = i_req;
        end
        // after serving m0 the pointer favours m1, and vice versa
        ptr_d = (i_advance && (o_grant != 2'b00)) ? o_grant[0] : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign o_ptr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/anton_neopixel_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : anton_neopixel_bus_arbiter
// Description : Shares the neopixel core register/buffer bus between two
//               requesters and sequences frame commits (CTRL write + polling).
//               ANTON_NEOPIXEL_ARB_WRITE_LOCK_EN blocks pixel-buffer writes
//               from requesters while a frame is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module anton_neopixel_bus_arbiter
    import anton_neopixel_bus_arbiter_pkg::*;
#(
    parameter int POLL_INTERVAL = 64,
    parameter int POLL_BITS     = 7
) (
    input  logic        busClk,
    input  logic        busReset,
    input  logic        m0Req,
    input  logic        m0Write,
    input  logic [13:0] m0Addr,
    input  logic [7:0]  m0DataIn,
    output logic        m0Ack,
    output logic [7:0]  m0DataOut,
    input  logic        m1Req,
    input  logic        m1Write,
    input  logic [13:0] m1Addr,
    input  logic [7:0]  m1DataIn,
    output logic        m1Ack,
    output logic [7:0]  m1DataOut,
    input  logic        frameCommit,
    input  logic        cfgLoop,
    input  logic        cfg32bit,
    input  logic        cfgLimit,
    output logic        frameBusy,
    output logic        frameDone,
    output logic [13:0] busAddr,
    output logic [7:0]  busDataIn,
    output logic        busWrite,
    output logic        busRead,
    input  logic [7:0]  busDataOut
);

    localparam logic [POLL_BITS-1:0] TIMER_RELOAD = POLL_BITS'(POLL_INTERVAL - 1);

    state_t               state_q,   state_d;
    owner_t               owner_q,   owner_d;
    logic                 rw_q,      rw_d;
    logic                 loop_q,    loop_d;
    logic                 pending_q, pending_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;
    logic [POLL_BITS-1:0] timer_q,   timer_d;
    logic                 ack0_q,    ack0_d;
    logic                 ack1_q,    ack1_d;
    logic [7:0]           data0_q,   data0_d;
    logic [7:0]           data1_q,   data1_d;
    logic [13:0]          addr_q,    addr_d;
    logic [7:0]           wdata_q,   wdata_d;
    logic                 wr_q,      wr_d;
    logic                 rd_q,      rd_d;

    logic       lock0, lock1;
    logic [1:0] req_elig;
    logic [1:0] rr_grant;
    logic       rr_ptr;
    logic       rr_adv;
    logic       poll_due;
    logic       commit_due;

`ifdef ANTON_NEOPIXEL_ARB_WRITE_LOCK_EN
    assign lock0 = busy_q & m0Write & ~m0Addr[13];
    assign lock1 = busy_q & m1Write & ~m1Addr[13];
`else
    assign lock0 = 1'b0;
    assign lock1 = 1'b0;
`endif

    assign req_elig   = {m1Req & ~lock1, m0Req & ~lock0};
    assign poll_due   = busy_q && (timer_q == '0);
    assign commit_due = pending_q && !busy_q;

    anton_rr_arbiter2 u_rr (
        .clk       (busClk),
        .rst       (busReset),
        .i_req     (req_elig),
        .i_advance (rr_adv),
        .o_grant   (rr_grant),
        .o_ptr     (rr_ptr)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rw_d      = rw_q;
        loop_d    = loop_q;
        pending_d = pending_q | frameCommit;
        busy_d    = busy_q;
        done_d    = 1'b0;
        timer_d   = (busy_q && (timer_q != '0)) ? timer_q - 1'b1 : timer_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        data0_d   = data0_q;
        data1_d   = data1_q;
        addr_d    = '0;
        wdata_d   = '0;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        rr_adv    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (poll_due) begin
                    owner_d = OWN_INT;
                    rw_d    = 1'b0;
                    addr_d  = REG_CTRL;
                    rd_d    = 1'b1;
                    state_d = ST_XFER;
                end else if (commit_due) begin
                    owner_d   = OWN_INT;
                    rw_d      = 1'b1;
                    addr_d    = REG_CTRL;
                    wdata_d   = ctrl_commit_word(cfg32bit, cfgLoop, cfgLimit);
                    wr_d      = 1'b1;
                    loop_d    = cfgLoop;
                    pending_d = frameCommit;
                    state_d   = ST_XFER;
                end else if (rr_grant != 2'b00) begin
                    rr_adv  = 1'b1;
                    state_d = ST_XFER;
                    // a tie resolves to the pointer, so rr_ptr selects m1 there
                    if (rr_grant[1] || (rr_grant == 2'b11 && rr_ptr)) begin
                        owner_d = OWN_M1;
                        rw_d    = m1Write;
                        addr_d  = m1Addr;
                        wdata_d = m1Write ? m1DataIn : 8'h00;
                        wr_d    = m1Write;
                        rd_d    = ~m1Write;
                    end else begin
                        owner_d = OWN_M0;
                        rw_d    = m0Write;
                        addr_d  = m0Addr;
                        wdata_d = m0Write ? m0DataIn : 8'h00;
                        wr_d    = m0Write;
                        rd_d    = ~m0Write;
                    end
                end
            end
            ST_XFER: begin
                state_d = rw_q ? ST_WR_ACK : ST_RD_WAIT;
                if (rw_q) begin
                    case (owner_q)
                        OWN_M0: ack0_d = 1'b1;
                        OWN_M1: ack1_d = 1'b1;
                        default: begin
                            // a looping frame never self-clears, so it is done at once
                            if (loop_q) begin
                                done_d = 1'b1;
                            end else begin
                                busy_d  = 1'b1;
                                timer_d = TIMER_RELOAD;
                            end
                        end
                    endcase
                end
            end
            ST_WR_ACK: state_d = ST_IDLE;
            ST_RD_WAIT: begin
                state_d = ST_RD_ACK;
                case (owner_q)
                    OWN_M0: begin
                        ack0_d  = 1'b1;
                        data0_d = busDataOut;
                    end
                    OWN_M1: begin
                        ack1_d  = 1'b1;
                        data1_d = busDataOut;
                    end
                    default: begin
                        if (!busDataOut[CTRL_RUN]) begin
                            busy_d = 1'b0;
                            done_d = 1'b1;
                        end else begin
                            timer_d = TIMER_RELOAD;
                        end
                    end
                endcase
            end
            ST_RD_ACK: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge busClk) begin
        if (busReset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_M0;
            rw_q      <= 1'b0;
            loop_q    <= 1'b0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timer_q   <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            data0_q   <= '0;
            data1_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rw_q      <= rw_d;
            loop_q    <= loop_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timer_q   <= timer_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            data0_q   <= data0_d;
            data1_q   <= data1_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
        end
    end

    assign m0Ack     = ack0_q;
    assign m0DataOut = data0_q;
    assign m1Ack     = ack1_q;
    assign m1DataOut = data1_q;
    assign frameBusy = busy_q;
    assign frameDone = done_q;
    assign busAddr   = addr_q;
    assign busDataIn = wdata_q;
    assign busWrite  = wr_q;
    assign busRead   = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_anton_neopixel_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_anton_neopixel_bus_arbiter
// Description : Directed bench with a small core model for the neopixel bus
//               arbiter (requester vectors, commit/poll sequencing, reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_anton_neopixel_bus_arbiter;

    localparam int          POLL_INTERVAL = 64;
    localparam logic [13:0] C_CTRL        = 14'h2002;

    logic        busClk = 1'b0;
    logic        busReset;
    logic        m0Req, m0Write, m1Req, m1Write;
    logic [13:0] m0Addr, m1Addr;
    logic [7:0]  m0DataIn, m1DataIn, m0DataOut, m1DataOut;
    logic        m0Ack, m1Ack;
    logic        frameCommit, cfgLoop, cfg32bit, cfgLimit;
    logic        frameBusy, frameDone;
    logic [13:0] busAddr;
    logic [7:0]  busDataIn;
    logic        busWrite, busRead;
    logic [7:0]  busDataOut;

    anton_neopixel_bus_arbiter #(.POLL_INTERVAL(POLL_INTERVAL), .POLL_BITS(7)) dut (
        .busClk(busClk), .busReset(busReset),
        .m0Req(m0Req), .m0Write(m0Write), .m0Addr(m0Addr), .m0DataIn(m0DataIn),
        .m0Ack(m0Ack), .m0DataOut(m0DataOut),
        .m1Req(m1Req), .m1Write(m1Write), .m1Addr(m1Addr), .m1DataIn(m1DataIn),
        .m1Ack(m1Ack), .m1DataOut(m1DataOut),
        .frameCommit(frameCommit), .cfgLoop(cfgLoop), .cfg32bit(cfg32bit),
        .cfgLimit(cfgLimit), .frameBusy(frameBusy), .frameDone(frameDone),
        .busAddr(busAddr), .busDataIn(busDataIn), .busWrite(busWrite),
        .busRead(busRead), .busDataOut(busDataOut)
    );

    always #5 busClk = ~busClk;

    int cyc = 0;
    always @(posedge busClk) cyc <= cyc + 1;

    // core model: memory plus a CTRL register whose run bit reads back set
    // until ctrl_rd_cnt reaches run_target
    logic [7:0] mem [0:16383];
    logic [7:0] ctrl_reg = 8'h00;
    logic [7:0] core_rd  = 8'h00;
    int         ctrl_rd_cnt = 0;
    int         run_target  = 0;
    assign busDataOut = core_rd;

    always @(posedge busClk) begin
        if (busWrite) begin
            mem[busAddr] <= busDataIn;
            if (busAddr == C_CTRL) ctrl_reg <= busDataIn;
        end
        if (busRead) begin
            if (busAddr == C_CTRL) begin
                core_rd     <= (ctrl_rd_cnt < run_target) ? ctrl_reg : (ctrl_reg & 8'hFB);
                ctrl_rd_cnt <= ctrl_rd_cnt + 1;
            end else begin
                core_rd <= mem[busAddr];
            end
        end
    end

    int ctrl_wr_n = 0, done_n = 0, both_ack_n = 0, poll_n = 0;
    int poll_cyc [0:63];
    always @(negedge busClk) begin
        if (busWrite && busAddr == C_CTRL) ctrl_wr_n <= ctrl_wr_n + 1;
        if (busRead && busAddr == C_CTRL && poll_n < 64) begin
            poll_cyc[poll_n] <= cyc;
            poll_n           <= poll_n + 1;
        end
        if (frameDone)      done_n     <= done_n + 1;
        if (m0Ack && m1Ack) both_ack_n <= both_ack_n + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          port;
        bit          wr;
        logic [13:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
    } vec_t;

    task automatic do_xfer(input vec_t v);
        int lat;
        bit got;
        @(posedge busClk); #1;
        if (v.port == 1'b0) begin
            m0Req = 1'b1; m0Write = v.wr; m0Addr = v.addr; m0DataIn = v.wdata;
        end else begin
            m1Req = 1'b1; m1Write = v.wr; m1Addr = v.addr; m1DataIn = v.wdata;
        end
        @(posedge busClk); #1;
        check("strobe", {busWrite, busRead, busAddr}, {v.wr, ~v.wr, v.addr});
        if (v.wr) check("wdata", busDataIn, v.wdata);
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(posedge busClk); #1;
            lat++;
            if ((v.port == 1'b0) ? m0Ack : m1Ack) got = 1'b1;
        end
        check("ack_latency", got ? lat : 0, v.wr ? 2 : 3);
        if (!v.wr) check("rdata", (v.port == 1'b0) ? m0DataOut : m1DataOut, v.exp_rdata);
        m0Req = 1'b0;
        m1Req = 1'b0;
    endtask

    task automatic pulse_commit();
        @(posedge busClk); #1; frameCommit = 1'b1;
        @(posedge busClk); #1; frameCommit = 1'b0;
    endtask

    task automatic wait_ctrl_write(input int budget, output int at, output logic [7:0] d, output bit ok);
        ok = 1'b0; at = 0; d = 8'h00;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge busClk); #1;
            if (busWrite && busAddr == C_CTRL) begin
                ok = 1'b1; at = cyc; d = busDataIn;
            end
        end
    endtask

    task automatic wait_done(input int budget, output int at, output bit ok);
        ok = 1'b0; at = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge busClk); #1;
            if (frameDone) begin
                ok = 1'b1; at = cyc;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    vec_t        vecs [7];
    logic [13:0] order [4];
    int          n, first_at, wr_at, w2_at, d_at, d1_at, p0;
    int          m0_at, m1_at;
    bit          ok, m0_seen, m1_seen, d_seen, exp_m1_late;
    logic [7:0]  d8, m0_rd;
    int          wr_before;

    initial begin
        vecs[0] = '{port: 1'b0, wr: 1'b1, addr: 14'h0005, wdata: 8'hA5, exp_rdata: 8'h00};
        vecs[1] = '{port: 1'b0, wr: 1'b0, addr: 14'h0005, wdata: 8'h00, exp_rdata: 8'hA5};
        vecs[2] = '{port: 1'b1, wr: 1'b1, addr: 14'h0123, wdata: 8'h3C, exp_rdata: 8'h00};
        vecs[3] = '{port: 1'b1, wr: 1'b0, addr: 14'h0123, wdata: 8'h00, exp_rdata: 8'h3C};
        vecs[4] = '{port: 1'b0, wr: 1'b0, addr: 14'h0123, wdata: 8'h00, exp_rdata: 8'h3C};
        vecs[5] = '{port: 1'b1, wr: 1'b1, addr: 14'h2000, wdata: 8'h7F, exp_rdata: 8'h00};
        vecs[6] = '{port: 1'b0, wr: 1'b0, addr: 14'h2000, wdata: 8'h00, exp_rdata: 8'h7F};

        busReset = 1'b1;
        m0Req = 1'b1; m0Write = 1'b1; m0Addr = 14'h0010; m0DataIn = 8'h11;
        m1Req = 1'b1; m1Write = 1'b1; m1Addr = 14'h0011; m1DataIn = 8'h22;
        frameCommit = 1'b0; cfgLoop = 1'b0; cfg32bit = 1'b0; cfgLimit = 1'b0;

        // reset with both requesters active
        for (int i = 0; i < 2; i++) begin
            @(posedge busClk); #1;
            check("reset_outputs",
                  {m0Ack, m0DataOut, m1Ack, m1DataOut, frameBusy, frameDone,
                   busAddr, busDataIn, busWrite, busRead}, 64'd0);
        end
        busReset = 1'b0;

        // both held: first grant m0, then strict alternation
        n = 0; first_at = -1;
        for (int i = 0; i < 20 && n < 4; i++) begin
            @(posedge busClk); #1;
            if (busWrite) begin
                if (n == 0) first_at = i;
                order[n] = busAddr;
                n++;
                if (n == 4) begin
                    m0Req = 1'b0; m1Req = 1'b0;
                end
            end
        end
        check("first_grant_cycle", first_at, 0);
        check("grant_order", {order[0], order[1], order[2], order[3]},
              {14'h0010, 14'h0011, 14'h0010, 14'h0011});
        repeat (4) @(posedge busClk);
        #1;
        check("no_double_ack", both_ack_n, 0);

        for (int i = 0; i < 7; i++) do_xfer(vecs[i]);

        // looping commit: done at write ack, busy never set
        cfgLoop = 1'b1; cfg32bit = 1'b0; cfgLimit = 1'b1;
        pulse_commit();
        wait_ctrl_write(10, wr_at, d8, ok);
        check("loop_commit_seen", ok, 1);
        check("loop_commit_data", d8, 8'h0E);
        @(posedge busClk); #1;
        check("loop_busy_done", {frameBusy, frameDone}, 2'b01);
        @(posedge busClk); #1;
        check("loop_done_pulse", {frameBusy, frameDone}, 2'b00);

        // normal commit: two run=1 polls then run=0
        run_target = ctrl_rd_cnt + 2;
        p0 = poll_n;
        cfgLoop = 1'b0; cfg32bit = 1'b1; cfgLimit = 1'b0;
        pulse_commit();
        wait_ctrl_write(10, wr_at, d8, ok);
        check("commit_seen", ok, 1);
        check("commit_data", d8, 8'h14);
        @(posedge busClk); #1;
        check("busy_at_ack", {frameBusy, frameDone}, 2'b10);
        wait_done(400, d_at, ok);
        check("frame_done_seen", ok, 1);
        check("busy_cleared_at_done", {frameBusy, frameDone}, 2'b01);
        check("poll_count", poll_n - p0, 3);
        check("first_poll_gap", poll_cyc[p0] - wr_at, POLL_INTERVAL + 1);
        check("poll_gap_1", poll_cyc[p0 + 1] - poll_cyc[p0], POLL_INTERVAL + 2);
        check("poll_gap_2", poll_cyc[p0 + 2] - poll_cyc[p0 + 1], POLL_INTERVAL + 2);
        check("done_to_last_poll", d_at - poll_cyc[p0 + 2], 2);
        @(posedge busClk); #1;
        check("done_one_pulse", frameDone, 0);

        // commits while busy merge into one write after frameDone
        run_target = ctrl_rd_cnt + 1;
        wr_before = ctrl_wr_n;
        pulse_commit();
        wait_ctrl_write(10, wr_at, d8, ok);
        check("commit2_seen", ok, 1);
        repeat (3) begin
            pulse_commit();
            repeat (3) @(posedge busClk);
        end
        wait_done(400, d1_at, ok);
        check("commit2_done", ok, 1);
        wait_ctrl_write(10, w2_at, d8, ok);
        check("merged_commit_seen", ok, 1);
        check("merged_commit_gap", w2_at - d1_at, 2);
        wait_done(400, d_at, ok);
        check("merged_frame_done", ok, 1);
        repeat (5) @(posedge busClk);
        #1;
        check("merged_write_count", ctrl_wr_n - wr_before, 2);
        check("idle_after_frames", frameBusy, 0);

        // buffer write from m1 during a frame, register read from m0
        run_target = ctrl_rd_cnt;
        pulse_commit();
        wait_ctrl_write(10, wr_at, d8, ok);
        check("commit3_seen", ok, 1);
        @(posedge busClk); #1;
        m0Req = 1'b1; m0Write = 1'b0; m0Addr = 14'h2000; m0DataIn = 8'h00;
        m1Req = 1'b1; m1Write = 1'b1; m1Addr = 14'h0040; m1DataIn = 8'h99;
        m0_seen = 1'b0; m1_seen = 1'b0; d_seen = 1'b0;
        m0_at = 0; m1_at = 0; d_at = 0; m0_rd = 8'h00;
        for (int i = 0; i < 300 && !(m0_seen && m1_seen && d_seen); i++) begin
            @(posedge busClk); #1;
            if (m0Ack && !m0_seen) begin
                m0_seen = 1'b1; m0_at = cyc; m0_rd = m0DataOut; m0Req = 1'b0;
            end
            if (m1Ack && !m1_seen) begin
                m1_seen = 1'b1; m1_at = cyc; m1Req = 1'b0;
            end
            if (frameDone && !d_seen) begin
                d_seen = 1'b1; d_at = cyc;
            end
        end
        check("lock_all_seen", {m0_seen, m1_seen, d_seen}, 3'b111);
        check("lock_m0_rdata", m0_rd, 8'h7F);
        check("lock_m0_before_done", m0_at < d_at, 1);
`ifdef ANTON_NEOPIXEL_ARB_WRITE_LOCK_EN
        exp_m1_late = 1'b1;
`else
        exp_m1_late = 1'b0;
`endif
        check("lock_m1_after_done", m1_at > d_at, exp_m1_late);
        m0Req = 1'b0; m1Req = 1'b0;
        repeat (3) @(posedge busClk);

        // reset landing in RD_WAIT kills the pending ack
        @(posedge busClk); #1;
        m0Req = 1'b1; m0Write = 1'b0; m0Addr = 14'h0005;
        @(posedge busClk); #1;
        check("rst_test_read_strobe", {busRead, busAddr}, {1'b1, 14'h0005});
        @(posedge busClk); #1;
        busReset = 1'b1; m0Req = 1'b0;
        @(posedge busClk); #1;
        check("rst_in_rd_wait", {m0Ack, busRead, busWrite, m0DataOut}, 11'd0);
        busReset = 1'b0;
        do_xfer(vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
